// File: rtl/adc_pattern_check_pkg.sv
// Shared encodings for the ADC test-pattern checker: the pattern modes and
// the checker FSM states.
package adc_pattern_check_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_RAMP   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/adc_pattern_check_chan.sv
// One checker channel: registered ADC input, expected-word generator seeded
// from the first registered sample, comparator and saturating error counter.
module adc_pat_chan
    import adc_pattern_check_pkg::*;
#(
    parameter int width = 14,
    parameter int err_w = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] adc_i,
    input  logic             clr_i,
    input  logic             seed_i,
    input  logic             run_i,
    input  mode_e            mode_i,
    input  logic [width-1:0] pat_a_i,
    input  logic [width-1:0] pat_b_i,
    output logic [err_w-1:0] err_o
);

    logic [width-1:0] d_q;
    logic [width-1:0] exp_q;
    logic [width-1:0] exp_d;
    logic [err_w-1:0] err_q;
    logic [err_w-1:0] err_d;
    logic             miss;

    assign miss = run_i && (d_q != exp_q);

    // NOTE: each always_comb target is given a default first, so no path can infer a latch.
    always_comb begin
        exp_d = exp_q;
        if (seed_i) begin
            case (mode_i)
                MODE_TOGGLE: exp_d = (d_q == pat_a_i) ? pat_b_i :
                                     (d_q == pat_b_i) ? pat_a_i : pat_b_i;
                MODE_RAMP:   exp_d = d_q + width'(1);
                default:     exp_d = pat_a_i;
            endcase
        end else if (run_i) begin
            case (mode_i)
                MODE_TOGGLE: exp_d = (exp_q == pat_a_i) ? pat_b_i : pat_a_i;
                MODE_RAMP:   exp_d = exp_q + width'(1);
                default:     exp_d = exp_q;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (clr_i) begin
            err_d = '0;
        end else if (miss && !(&err_q)) begin
            err_d = err_q + err_w'(1);
        end
    end

    // NOTE: the sample register is reset along with the rest, so a run started
    // straight out of reset never seeds from stale capture data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q   <= '0;
            exp_q <= '0;
            err_q <= '0;
        end else begin
            d_q   <= adc_i;
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: rtl/adc_pattern_check.sv
// AD9258 test-pattern checker: counts per-channel mismatches of the captured
// words against a fixed, toggle or ramp sequence over a programmable window.
module adc_pattern_check
    import adc_pattern_check_pkg::*;
#(
    parameter int width  = 14,
    parameter int wlen_w = 16,
    parameter int err_w  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [width-1:0]  adc0,
    input  logic [width-1:0]  adc1,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [width-1:0]  pat_a,
    input  logic [width-1:0]  pat_b,
    input  logic [wlen_w-1:0] win_len,
    output logic              busy,
    output logic              done,
    output logic [err_w-1:0]  err0,
    output logic [err_w-1:0]  err1,
    output logic              pass
);

    state_e            state_q;
    mode_e             mode_q;
    logic [width-1:0]  pat_a_q;
    logic [width-1:0]  pat_b_q;
    logic [wlen_w-1:0] win_len_q;
    logic [wlen_w-1:0] win_cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              start_ok;
    logic              seed;
    logic              run;

    assign start_ok = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign seed     = (state_q == ST_SEED);
    assign run      = (state_q == ST_RUN);

    // NOTE: state and its registered outputs change together on non-blocking
    // assignments, so busy and done can never be seen high at the same time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_FIXED;
            pat_a_q   <= '0;
            pat_b_q   <= '0;
            win_len_q <= '0;
            win_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        mode_q    <= mode_e'(mode);
                        pat_a_q   <= pat_a;
                        pat_b_q   <= pat_b;
                        win_len_q <= win_len;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= ST_SEED;
                    end
                end
                ST_SEED: begin
                    win_cnt_q <= win_len_q;
                    state_q   <= ST_RUN;
                end
                ST_RUN: begin
                    // A zero load wraps through all-ones first, giving 2^wlen_w compares.
                    win_cnt_q <= win_cnt_q - wlen_w'(1);
                    if (win_cnt_q == wlen_w'(1)) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    adc_pat_chan #(.width(width), .err_w(err_w)) u_chan0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .adc_i   (adc0),
        .clr_i   (start_ok),
        .seed_i  (seed),
        .run_i   (run),
        .mode_i  (mode_q),
        .pat_a_i (pat_a_q),
        .pat_b_i (pat_b_q),
        .err_o   (err0)
    );

    adc_pat_chan #(.width(width), .err_w(err_w)) u_chan1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .adc_i   (adc1),
        .clr_i   (start_ok),
        .seed_i  (seed),
        .run_i   (run),
        .mode_i  (mode_q),
        .pat_a_i (pat_a_q),
        .pat_b_i (pat_b_q),
        .err_o   (err1)
    );

    assign busy = busy_q;
    assign done = done_q;
    assign pass = done_q && (err0 == '0) && (err1 == '0);

endmodule

// File: doc/adc_pattern_check.md
Name: adc_pattern_check

Overview:
- Downstream of the IDDR2 ADC capture stage. Consumes the de-interleaved 14-bit words adc0/adc1 while the AD9258 runs a test-pattern mode.
- Over a programmable window, compares each channel against an expected sequence and counts mismatches per channel.
- Used at bring-up and after clock changes to confirm DDR capture alignment before the data path goes live.
- The result is read by the local control bus.

Parameters:
- width, 14, ADC sample width; must match the capture stage.
- wlen_w, 16, width of win_len and of the internal window counter.
- err_w, 16, width of each per-channel error counter.

Ports:
- clk  in  1  ADC data clock; same clock as the capture stage.
- rst_n  in  1  reset; asynchronous assert, active-low.
- adc0  in  width  channel-0 sample from the capture stage.
- adc1  in  width  channel-1 sample from the capture stage.
- start  in  1  one-cycle pulse; begins a check run.
- mode  in  2  0 = fixed, 1 = toggle, 2 = ramp, 3 = reserved (behaves as fixed).
- pat_a  in  width  fixed word, or first toggle word.
- pat_b  in  width  second toggle word.
- win_len  in  wlen_w  number of compared samples; 0 means 2^wlen_w.
- busy  out  1  high in SEED and RUN.
- done  out  1  high in DONE.
- err0  out  err_w  channel-0 mismatch count.
- err1  out  err_w  channel-1 mismatch count.
- pass  out  1  done and err0==0 and err1==0.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous and active-low. All state and outputs clear on reset: state=IDLE, busy=0, done=0, pass=0, err0=err1=0, input registers=0.
- Reset mid-run aborts the run with no partial result kept.
- Input stage: adc0/adc1 are registered into d0/d1 every cycle. A sample on the inputs at cycle t is seen in d at t+1.
- FSM states: IDLE, SEED, RUN, DONE.
- IDLE or DONE with start=1:
  - Latch mode, pat_a, pat_b, win_len.
  - Clear err0/err1, done and pass.
  - Go to SEED.
- start while busy is ignored. The latched configuration is immune to input changes during a run.
- SEED lasts one cycle. The d sample in this cycle is never compared and never counted. Per-channel expectation is set up as follows:
  - fixed: exp = pat_a.
  - toggle: next exp = pat_b if d==pat_a; exp = pat_a if d==pat_b; if neither, exp = pat_b (as if d had been pat_a).
  - ramp: next exp = d+1, modulo 2^width.
- Load the window counter with win_len, then go to RUN.
- RUN lasts exactly N cycles, where N = win_len, or 2^wlen_w if win_len==0. Each cycle, per channel:
  - Compare d against exp.
  - On mismatch, increment err. err saturates at all-ones and never wraps.
  - Advance exp: fixed holds; toggle swaps pat_a/pat_b; ramp sets exp = exp+1 (wrap 3FFF->0).
- Ramp mode tracks the expected count, not the received value. One corrupted sample therefore gives one error, not two.
- Decrement the window counter each RUN cycle. On the last compare cycle, go to DONE the next cycle.
- DONE: done=1, pass as defined. err0/err1 hold until the next start or reset.
- busy and done are never high together.
- Latency: with start at cycle t, SEED is at t+1 and the first compare is at t+2 using adc input from t+1. done rises at t+2+N.
- err counters are final on the cycle done rises.

Decomposition:
- Shared include (adc_pattern_defs.vh):
  - localparams MODE_FIXED=0, MODE_TOGGLE=1, MODE_RAMP=2.
  - State encodings ST_IDLE, ST_SEED, ST_RUN, ST_DONE.
- Sub-module adc_pat_chan, instantiated once per channel. It contains:
  - the per-channel registered input;
  - the expected-value generator with seed logic;
  - the comparator;
  - the saturating error counter.
- The top level holds the FSM, configuration latch and window counter, and drives seed/run strobes to both channels.

Test Plan:
1. Fixed mode: pat_a=0x2AAA, both channels constant 0x2AAA, win_len=100, start -> busy for 101 cycles, done at t+102, err0=err1=0, pass=1.
2. Toggle mode: pat_a=0x1555, pat_b=0x2AAA; ch0 starts on pat_b phase, ch1 on pat_a; ch1 bit 3 flipped on 5 samples; win_len=64 -> err0=0, err1=5, pass=0.
3. Ramp wrap: both channels ramp from 0x3FF0 across 0x3FFF->0; one ch0 sample replaced by 0x0000 mid-window; win_len=40 -> err0=1, err1=0.
4. Saturation: err_w=4, fixed mode with ch0 all mismatching, win_len=20 -> err0=0xF, err1=0, done=1.
5. Control edges: start pulsed again during RUN is ignored; win_len=0 with wlen_w=4 runs 16 compares; start in DONE clears err and reruns.
6. Reset mid-RUN: rst_n low for 1 cycle at compare 10 -> busy=done=pass=0 and err=0 immediately; a new start completes normally.
